// File: rtl/booth_mult_sequencer.sv
// ============================================================================
// Module   : booth_mult_sequencer
// Brief    : Handshaked control stage for a sequential radix-4 Booth core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult_sequencer #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 49,
  parameter int CNT_W       = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_mul_rst,
  output logic                 o_mul_load,
  output logic [WIDTH-1:0]     o_mul_a,
  output logic [WIDTH-1:0]     o_mul_b,
  input  logic [2*WIDTH-1:0]   i_mul_product,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*WIDTH-1:0]   o_result,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_job_count
);

  localparam int LAT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  if (MUL_LATENCY < 1) begin : g_bad_latency
    $error("booth_mult_sequencer: MUL_LATENCY must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]     job_q, job_d;
  logic                 clr_w;
  logic                 load_w;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      job_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      job_q    <= job_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    job_d    = job_q;
    clr_w    = 1'b0;
    load_w   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        clr_w   = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        load_w  = 1'b1;
        cnt_d   = LAT_W'(MUL_LATENCY - 1);
        state_d = S_RUN;
      end
      S_RUN: begin
        // Core finishes one cycle before the final RUN cycle; sample on the last.
        if (cnt_q == '0) begin
          result_d = i_mul_product;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      S_DONE: begin
        if (i_ready) begin
          job_d   = job_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_valid     = (state_q == S_DONE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_mul_rst   = i_rst | clr_w;
  assign o_mul_load  = load_w & ~i_rst;
  assign o_mul_a     = a_q;
  assign o_mul_b     = b_q;
  assign o_result    = result_q;
  assign o_job_count = job_q;

endmodule

`default_nettype wire
